// File: rtl/hwpe_tcdm_stream_arbiter.sv
// rtl/hwpe_tcdm_stream_arbiter.sv - round-robin TCDM port arbiter with stall lock and in-order response routing
module hwpe_tcdm_stream_arbiter #(
    parameter int N_REQ           = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic [N_REQ-1:0]              req_i,
    output logic [N_REQ-1:0]              gnt_o,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   add_i,
    input  logic [N_REQ-1:0]              type_i,
    input  logic [N_REQ*BE_WIDTH-1:0]     be_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   data_i,
    output logic [N_REQ*DATA_WIDTH-1:0]   r_data_o,
    output logic [N_REQ-1:0]              r_valid_o,
    output logic                          tcdm_req_o,
    input  logic                          tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]         tcdm_add_o,
    output logic                          tcdm_type_o,
    output logic [BE_WIDTH-1:0]           tcdm_be_o,
    output logic [DATA_WIDTH-1:0]         tcdm_data_o,
    input  logic [DATA_WIDTH-1:0]         tcdm_r_data_i,
    input  logic                          tcdm_r_valid_i,
    output logic [CNT_W-1:0]              outstanding_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ADDR_WIDTH-1:0] add_a  [N_REQ];
    logic [BE_WIDTH-1:0]   be_a   [N_REQ];
    logic [DATA_WIDTH-1:0] data_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign add_a[g]  = add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign be_a[g]   = be_i[g*BE_WIDTH +: BE_WIDTH];
        assign data_a[g] = data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [IDX_W-1:0] rr_ptr;
    logic             lock;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;

    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] rr_next;
    logic             found;
    logic             full;
    logic             hs;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // A stalled request keeps its slot so the TCDM side sees a stable transaction.
    always_comb begin
        win   = rr_ptr;
        cand  = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            if (!found && req_i[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        if (lock) begin
            win = lock_idx;
        end
    end

    assign full    = (count == CNT_W'(MAX_OUTSTANDING));
    assign head    = fifo_mem[rd_ptr];
    assign rr_next = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;

    assign tcdm_req_o  = req_i[win] & ~full;
    assign tcdm_add_o  = add_a[win];
    assign tcdm_type_o = type_i[win];
    assign tcdm_be_o   = be_a[win];
    assign tcdm_data_o = data_a[win];

    assign hs  = tcdm_req_o & tcdm_gnt_i;
    assign pop = tcdm_r_valid_i & (count != '0);

    always_comb begin
        gnt_o     = '0;
        r_valid_o = '0;
        if (hs) begin
            gnt_o[win] = 1'b1;
        end
        if (pop) begin
            r_valid_o[head] = 1'b1;
        end
    end

    assign r_data_o      = {N_REQ{tcdm_r_data_i}};
    assign outstanding_o = count;
    assign busy_o        = (|req_i) | (count != '0);
    assign err_o         = err_q;

    always_ff @(posedge clk) begin
        if (hs && !clear_i) begin
            fifo_mem[wr_ptr] <= win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (hs) begin
                wr_ptr <= ptr_inc(wr_ptr);
                rr_ptr <= rr_next;
                lock   <= 1'b0;
            end else if (tcdm_req_o) begin
                lock     <= 1'b1;
                lock_idx <= win;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (tcdm_r_valid_i && (count == '0)) begin
                err_q <= 1'b1;
            end
            case ({hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_tcdm_stream_arbiter.sv
// tb/tb_hwpe_tcdm_stream_arbiter.sv - directed self-checking bench for hwpe_tcdm_stream_arbiter
module tb_hwpe_tcdm_stream_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear_i;
    logic [3:0]   req_i;
    logic [3:0]   gnt_o;
    logic [127:0] add_i;
    logic [3:0]   type_i;
    logic [15:0]  be_i;
    logic [127:0] data_i;
    logic [127:0] r_data_o;
    logic [3:0]   r_valid_o;
    logic         tcdm_req_o;
    logic         tcdm_gnt_i;
    logic [31:0]  tcdm_add_o;
    logic         tcdm_type_o;
    logic [3:0]   tcdm_be_o;
    logic [31:0]  tcdm_data_o;
    logic [31:0]  tcdm_r_data_i;
    logic         tcdm_r_valid_i;
    logic [2:0]   outstanding_o;
    logic         busy_o;
    logic         err_o;

    logic [31:0] add_a [4];
    int n_checks = 0;
    int n_fail   = 0;
    int gcnt [4];

    always #5 clk = ~clk;

    assign add_i  = {add_a[3], add_a[2], add_a[1], add_a[0]};
    assign type_i = 4'b0101;
    assign be_i   = {4'h8, 4'h4, 4'h2, 4'h1};
    assign data_i = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

    hwpe_tcdm_stream_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (clear_i),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .add_i          (add_i),
        .type_i         (type_i),
        .be_i           (be_i),
        .data_i         (data_i),
        .r_data_o       (r_data_o),
        .r_valid_o      (r_valid_o),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_type_o    (tcdm_type_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_data_o    (tcdm_data_o),
        .tcdm_r_data_i  (tcdm_r_data_i),
        .tcdm_r_valid_i (tcdm_r_valid_i),
        .outstanding_o  (outstanding_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then settle for sampling.
    task automatic cyc(input logic [3:0] rq, input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        req_i          = rq;
        tcdm_gnt_i     = g;
        tcdm_r_valid_i = rv;
        tcdm_r_data_i  = rd;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_i = 1'b0;
        req_i = '0;
        tcdm_gnt_i = 1'b0;
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i = '0;
        for (int i = 0; i < 4; i++) begin
            add_a[i] = 32'hA000_0000 + 32'(i) * 32'h100;
            gcnt[i]  = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", gnt_o, 4'b0000);
        check("rst_rvalid", r_valid_o, 4'b0000);
        check("rst_outst", outstanding_o, 3'd0);
        check("rst_err", err_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst_n = 1'b1;

        // single requester, back-to-back with one-cycle response latency
        for (int c = 0; c <= 10; c++) begin
            add_a[0] = 32'h100 + 32'(c);
            cyc((c < 10) ? 4'b0001 : 4'b0000, 1'b1, (c >= 1), 32'hFFFF_0000 ^ (32'h100 + 32'(c) - 32'd1));
            if (c < 10) begin
                check("single_gnt", gnt_o, 4'b0001);
                check("single_add", tcdm_add_o, 32'h100 + 32'(c));
            end
            if (c >= 1) begin
                check("single_rvalid", r_valid_o, 4'b0001);
                check("single_rdata", r_data_o[31:0], 32'hFFFF_0000 ^ (32'h100 + 32'(c) - 32'd1));
            end
        end
        add_a[0] = 32'hA000_0000;
        cyc(4'b0000, 1'b0, 1'b0, 32'h0);
        check("single_outst_end", outstanding_o, 3'd0);

        // fairness from rr_ptr=0
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cyc(4'b1111, 1'b1, (c >= 1), 32'h0);
            check("fair_gnt", gnt_o, 128'(1) << (c % 4));
            if (c >= 1) check("fair_route", r_valid_o, 128'(1) << ((c - 1) % 4));
            for (int i = 0; i < 4; i++) if (gnt_o[i]) gcnt[i]++;
        end
        cyc(4'b0000, 1'b1, 1'b1, 32'h0);
        check("fair_route_last", r_valid_o, 4'b1000);
        for (int i = 0; i < 4; i++) check("fair_count", gcnt[i], 4);

        // stall lock: move rr_ptr to 1, then stall index 1 for 3 cycles
        cyc(4'b0001, 1'b1, 1'b0, 32'h0);
        check("lock_pre_gnt", gnt_o, 4'b0001);
        for (int s = 0; s < 4; s++) begin
            cyc(4'b0110, (s == 3), (s == 0), 32'h0);
            check("lock_req", tcdm_req_o, 1'b1);
            check("lock_add", tcdm_add_o, 32'hA000_0100);
            check("lock_gnt", gnt_o, (s == 3) ? 4'b0010 : 4'b0000);
        end
        cyc(4'b0110, 1'b1, 1'b0, 32'h0);
        check("lock_next_gnt", gnt_o, 4'b0100);
        check("lock_next_add", tcdm_add_o, 32'hA000_0200);
        cyc(4'b0000, 1'b0, 1'b1, 32'h0);
        check("lock_rv1", r_valid_o, 4'b0010);
        cyc(4'b0000, 1'b0, 1'b1, 32'h0);
        check("lock_rv2", r_valid_o, 4'b0100);

        // locked requester drops req: master request must fall
        cyc(4'b1000, 1'b0, 1'b0, 32'h0);
        check("drop_req_on", tcdm_req_o, 1'b1);
        cyc(4'b0001, 1'b0, 1'b0, 32'h0);
        check("drop_req_off", tcdm_req_o, 1'b0);
        check("drop_gnt", gnt_o, 4'b0000);
        cyc(4'b1000, 1'b1, 1'b0, 32'h0);
        check("drop_regnt", gnt_o, 4'b1000);
        cyc(4'b0000, 1'b0, 1'b1, 32'h0);
        check("drop_rv", r_valid_o, 4'b1000);

        // outstanding limit
        for (int c = 0; c < 4; c++) begin
            cyc(4'b0001, 1'b1, 1'b0, 32'h0);
            check("lim_gnt", gnt_o, 4'b0001);
        end
        cyc(4'b0001, 1'b1, 1'b0, 32'h0);
        check("lim_full_outst", outstanding_o, 3'd4);
        check("lim_full_req", tcdm_req_o, 1'b0);
        cyc(4'b0001, 1'b1, 1'b1, 32'h0);
        check("lim_pop_rv", r_valid_o, 4'b0001);
        check("lim_pop_req", tcdm_req_o, 1'b0);
        cyc(4'b0001, 1'b1, 1'b0, 32'h0);
        check("lim_outst3", outstanding_o, 3'd3);
        check("lim_regnt", gnt_o, 4'b0001);
        for (int c = 0; c < 4; c++) begin
            cyc(4'b0000, 1'b0, 1'b1, 32'h0);
            check("lim_drain", r_valid_o, 4'b0001);
        end
        cyc(4'b0000, 1'b0, 1'b0, 32'h0);
        check("lim_outst0", outstanding_o, 3'd0);

        // routing: grants 2,0,3 then responses A,B,C
        cyc(4'b0100, 1'b1, 1'b0, 32'h0);
        check("route_g2", gnt_o, 4'b0100);
        check("route_be2", tcdm_be_o, 4'h4);
        check("route_type2", tcdm_type_o, 1'b1);
        cyc(4'b0001, 1'b1, 1'b0, 32'h0);
        check("route_g0", gnt_o, 4'b0001);
        check("route_data0", tcdm_data_o, 32'hD0);
        cyc(4'b1000, 1'b1, 1'b0, 32'h0);
        check("route_g3", gnt_o, 4'b1000);
        check("route_type3", tcdm_type_o, 1'b0);
        cyc(4'b0000, 1'b0, 1'b1, 32'hAAAA_0001);
        check("route_rv_a", r_valid_o, 4'b0100);
        check("route_rd_a", r_data_o, {4{32'hAAAA_0001}});
        cyc(4'b0000, 1'b0, 1'b1, 32'hBBBB_0002);
        check("route_rv_b", r_valid_o, 4'b0001);
        check("route_rd_b", r_data_o, {4{32'hBBBB_0002}});
        cyc(4'b0000, 1'b0, 1'b1, 32'hCCCC_0003);
        check("route_rv_c", r_valid_o, 4'b1000);
        check("route_rd_c", r_data_o, {4{32'hCCCC_0003}});

        // spurious response, sticky error, clear
        cyc(4'b0000, 1'b0, 1'b1, 32'h0);
        check("err_rv_none", r_valid_o, 4'b0000);
        cyc(4'b0000, 1'b0, 1'b0, 32'h0);
        check("err_set", err_o, 1'b1);
        cyc(4'b0010, 1'b1, 1'b0, 32'h0);
        check("err_held", err_o, 1'b1);
        check("err_pre_gnt", gnt_o, 4'b0010);
        @(negedge clk);
        clear_i = 1'b1;
        req_i = '0;
        tcdm_gnt_i = 1'b0;
        @(negedge clk);
        clear_i = 1'b0;
        req_i = 4'b1010;
        #1;
        check("clr_err", err_o, 1'b0);
        check("clr_outst", outstanding_o, 3'd0);
        check("clr_rrptr", tcdm_add_o, 32'hA000_0100);
        cyc(4'b0000, 1'b0, 1'b1, 32'h0);
        check("clr_forgot_rv", r_valid_o, 4'b0000);
        cyc(4'b0000, 1'b0, 1'b0, 32'h0);
        check("clr_forgot_err", err_o, 1'b1);

        // async reset mid-burst
        cyc(4'b1111, 1'b1, 1'b0, 32'h0);
        cyc(4'b1111, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("burst_outst", outstanding_o, 3'd2);
        tcdm_r_valid_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outst", outstanding_o, 3'd0);
        check("arst_err", err_o, 1'b0);
        check("arst_rvalid", r_valid_o, 4'b0000);
        check("arst_rrptr", tcdm_add_o, 32'hA000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        req_i = '0;
        tcdm_r_valid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
